// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port memory arbiter/sequencer for fetch and data stages
module mem_arbiter #(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 16,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    input  logic              d_re,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              if_stall,
    output logic              d_stall,
    output logic              mem_re,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_DATA  = 2'd1;
    localparam logic [1:0] S_FETCH = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              mem_re_q, mem_re_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              if_done_q, if_done_d;
    logic              d_done_q, d_done_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic              d_req, f_req;

    // Done mask keeps a requester from being re-served in its completion cycle.
    assign d_req = (d_re | d_we) & ~d_done_q;
    assign f_req = if_req & ~if_done_q;

    assign if_stall  = f_req;
    assign d_stall   = d_req;
    assign if_done   = if_done_q;
    assign d_done    = d_done_q;
    assign if_rdata  = if_rdata_q;
    assign d_rdata   = d_rdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        mem_re_d    = mem_re_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        if_done_d   = 1'b0;
        d_done_d    = 1'b0;
        if_rdata_d  = if_rdata_q;
        d_rdata_d   = d_rdata_q;
        case (state_q)
            S_IDLE: begin
                if (d_req) begin
                    // Read and write together resolve to a write.
                    state_d     = S_DATA;
                    cnt_d       = CNT_LOAD;
                    mem_we_d    = d_we;
                    mem_re_d    = ~d_we;
                    mem_addr_d  = d_addr;
                    mem_wdata_d = d_we ? d_wdata : '0;
                end else if (f_req) begin
                    state_d     = S_FETCH;
                    cnt_d       = CNT_LOAD;
                    mem_we_d    = 1'b0;
                    mem_re_d    = 1'b1;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                end
            end
            S_DATA, S_FETCH: begin
                if (cnt_q == '0) begin
                    state_d     = S_IDLE;
                    mem_re_d    = 1'b0;
                    mem_we_d    = 1'b0;
                    mem_addr_d  = '0;
                    mem_wdata_d = '0;
                    if (state_q == S_FETCH) begin
                        if_done_d  = 1'b1;
                        if_rdata_d = mem_rdata;
                    end else begin
                        d_done_d = 1'b1;
                        if (mem_re_q) begin
                            d_rdata_d = mem_rdata;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d     = S_IDLE;
                cnt_d       = '0;
                mem_re_d    = 1'b0;
                mem_we_d    = 1'b0;
                mem_addr_d  = '0;
                mem_wdata_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            if_done_q   <= 1'b0;
            d_done_q    <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            mem_re_q    <= mem_re_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            if_done_q   <= if_done_d;
            d_done_q    <= d_done_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter (MEM_LAT=4 and MEM_LAT=1 instances)
module tb_mem_arbiter;
    localparam int L   = 4;
    localparam int TMO = 200;

    typedef struct {
        logic        re;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] rdata;
    } exp_t;

    logic        clk, rst;
    logic        if_req, d_re, d_we;
    logic [15:0] if_addr, d_addr, d_wdata;
    logic        if_done, d_done, if_stall, d_stall, mem_re, mem_we;
    logic [15:0] if_rdata, d_rdata, mem_addr, mem_wdata, mem_rdata;

    logic        if_req1, d_re1, d_we1;
    logic [15:0] if_addr1, d_addr1, d_wdata1;
    logic        if_done1, d_done1, if_stall1, d_stall1, mem_re1, mem_we1;
    logic [15:0] if_rdata1, d_rdata1, mem_addr1, mem_wdata1, mem_rdata1;

    int errors = 0;
    int checks = 0;
    exp_t fq[$];
    exp_t dq[$];
    logic [15:0] mem_img [logic [15:0]];
    logic [15:0] exp_drd;

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(L)) u_dut (
        .clk(clk), .rst(rst), .if_req(if_req), .if_addr(if_addr),
        .d_re(d_re), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .if_done(if_done), .if_rdata(if_rdata), .d_done(d_done), .d_rdata(d_rdata),
        .if_stall(if_stall), .d_stall(d_stall), .mem_re(mem_re), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    mem_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1)) u_dut1 (
        .clk(clk), .rst(rst), .if_req(if_req1), .if_addr(if_addr1),
        .d_re(d_re1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
        .if_done(if_done1), .if_rdata(if_rdata1), .d_done(d_done1), .d_rdata(d_rdata1),
        .if_stall(if_stall1), .d_stall(d_stall1), .mem_re(mem_re1), .mem_we(mem_we1),
        .mem_addr(mem_addr1), .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] rd(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'h3C5A;
    endfunction

    function automatic logic [15:0] mem_val(input logic [15:0] a);
        if (mem_img.exists(a)) return mem_img[a];
        return rd(a);
    endfunction

    // Memory model: contents are only meaningful while a read is enabled.
    always @(negedge clk) mem_rdata = mem_re ? mem_val(mem_addr) : 16'hDEAD;
    assign mem_rdata1 = mem_re1 ? rd(mem_addr1) : 16'hDEAD;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h @%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_range(input string name, input int v, input int lo, input int hi);
        checks++;
        if (v < lo || v > hi) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d..%0d @%0t", name, v, lo, hi, $time);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=event required=none @%0t", name, $time);
    endtask

    task automatic fetch_txn(input logic [15:0] a, output int lat, output int oth);
        exp_t e;
        if_addr = a;
        if_req  = 1'b1;
        e.re = 1'b1; e.we = 1'b0; e.addr = a; e.wdata = 16'h0; e.rdata = mem_val(a);
        fq.push_back(e);
        lat = 0;
        oth = 0;
        do begin
            @(negedge clk);
            lat++;
            if (d_done) oth++;
        end while (!if_done && lat < TMO);
        if (!if_done) fail("fetch_timeout");
    endtask

    // op: 0 = read, 1 = write, 2 = read+write (treated as write)
    task automatic data_txn(input int op, input logic [15:0] a, input logic [15:0] wd,
                            output int lat, output int oth);
        exp_t e;
        d_addr  = a;
        d_wdata = wd;
        d_re    = (op != 1);
        d_we    = (op != 0);
        e.re    = (op == 0);
        e.we    = (op != 0);
        e.addr  = a;
        e.wdata = e.we ? wd : 16'h0;
        e.rdata = e.we ? exp_drd : mem_val(a);
        exp_drd = e.rdata;
        dq.push_back(e);
        lat = 0;
        oth = 0;
        do begin
            @(negedge clk);
            lat++;
            if (if_done) oth++;
        end while (!d_done && lat < TMO);
        if (!d_done) fail("data_timeout");
    endtask

    logic        busy, prev_busy, prev_if_done, prev_d_done;
    logic        run_re, run_we, run_stable;
    logic [15:0] run_addr, run_wdata;
    int          run_len;

    task automatic check_run(input string p, input exp_t e);
        chk({p, "_run_len"}, run_len, L);
        chk({p, "_run_stable"}, run_stable, 1'b1);
        chk({p, "_run_op"}, {run_re, run_we}, {e.re, e.we});
        chk({p, "_run_addr"}, run_addr, e.addr);
        chk({p, "_run_wdata"}, run_wdata, e.wdata);
    endtask

    // Monitor: tracks each memory busy window and checks it when the done pulse appears.
    initial begin
        exp_t e;
        prev_busy = 1'b0; prev_if_done = 1'b0; prev_d_done = 1'b0; run_len = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_busy = 1'b0; prev_if_done = 1'b0; prev_d_done = 1'b0; run_len = 0;
            end else begin
                busy = mem_re | mem_we;
                if (busy) begin
                    if (!prev_busy) begin
                        run_len = 1; run_re = mem_re; run_we = mem_we;
                        run_addr = mem_addr; run_wdata = mem_wdata; run_stable = 1'b1;
                    end else begin
                        run_len++;
                        if ({mem_re, mem_we, mem_addr, mem_wdata} !== {run_re, run_we, run_addr, run_wdata})
                            run_stable = 1'b0;
                    end
                end else begin
                    chk("idle_mem_zero", {mem_addr, mem_wdata}, 32'h0);
                end
                if (if_done) begin
                    chk("if_done_pulse", prev_if_done, 1'b0);
                    if (fq.size() == 0) fail("if_done_unexpected");
                    else begin
                        e = fq.pop_front();
                        chk("if_rdata", if_rdata, e.rdata);
                        check_run("if", e);
                    end
                end
                if (d_done) begin
                    chk("d_done_pulse", prev_d_done, 1'b0);
                    if (dq.size() == 0) fail("d_done_unexpected");
                    else begin
                        e = dq.pop_front();
                        chk("d_rdata", d_rdata, e.rdata);
                        check_run("d", e);
                    end
                end
                prev_busy = busy; prev_if_done = if_done; prev_d_done = d_done;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            #2;
            chk("if_stall", if_stall, if_req & ~if_done);
            chk("d_stall", d_stall, (d_re | d_we) & ~d_done);
        end
    end

    int lat_f, oth_f, lat_d, oth_d;

    initial begin
        rst = 1'b1;
        if_req = 0; d_re = 0; d_we = 0; if_addr = 0; d_addr = 0; d_wdata = 0;
        if_req1 = 0; d_re1 = 0; d_we1 = 0; if_addr1 = 0; d_addr1 = 0; d_wdata1 = 0;
        exp_drd = 16'h0;

        repeat (2) @(negedge clk);
        chk("rst_flags", {if_done, d_done, if_stall, d_stall, mem_re, mem_we}, 0);
        chk("rst_rdata", {if_rdata, d_rdata}, 0);
        chk("rst_mem", {mem_addr, mem_wdata}, 0);
        chk("rst_flags1", {if_done1, d_done1, mem_re1, mem_we1, if_rdata1, d_rdata1}, 0);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("post_rst_stall", {if_stall, d_stall}, 0);
        chk("post_rst_mem", {mem_re, mem_we, mem_addr}, 0);

        mem_img[16'h0010] = 16'hABCD;
        fetch_txn(16'h0010, lat_f, oth_f);
        chk("t2_lat", lat_f, L + 1);
        if_req = 1'b0;

        mem_img[16'h0010] = 16'h1111;
        mem_img[16'h8000] = 16'h5555;
        fork
            begin fetch_txn(16'h0010, lat_f, oth_f); if_req = 1'b0; end
            begin data_txn(0, 16'h8000, 16'h0, lat_d, oth_d); d_re = 1'b0; d_we = 1'b0; end
        join
        chk("t3_d_lat", lat_d, L + 1);
        chk("t3_f_lat", lat_f, 2 * L + 2);

        data_txn(1, 16'h0020, 16'h1234, lat_d, oth_d);
        chk("t4_lat", lat_d, L + 1);
        chk("t4_d_rdata_kept", d_rdata, 16'h5555);
        d_we = 1'b0;

        if_addr = 16'h0040;
        if_req  = 1'b1;
        fq.push_back('{re: 1'b1, we: 1'b0, addr: 16'h0040, wdata: 16'h0, rdata: mem_val(16'h0040)});
        @(negedge clk);
        chk("t5_mem_re_busy", mem_re, 1'b1);
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("t5_mem_re_abort", {mem_re, mem_we, if_done}, 0);
        chk("t5_rdata_cleared", {if_rdata, d_rdata}, 0);
        exp_drd = 16'h0;
        @(negedge clk);
        #1 rst = 1'b0;
        lat_f = 0;
        do begin
            @(negedge clk);
            lat_f++;
        end while (!if_done && lat_f < TMO);
        chk("t5_lat_after_release", lat_f, L + 1);
        if_req = 1'b0;

        d_re1 = 1'b1; d_we1 = 1'b1; d_addr1 = 16'h0030; d_wdata1 = 16'hBEEF;
        @(negedge clk);
        chk("l1_wr_en", {mem_we1, mem_re1, d_done1}, 3'b100);
        chk("l1_wr_bus", {mem_addr1, mem_wdata1}, {16'h0030, 16'hBEEF});
        @(negedge clk);
        chk("l1_wr_done", {mem_we1, mem_re1, d_done1, d_stall1}, 4'b0010);
        chk("l1_d_rdata_kept", d_rdata1, 16'h0);
        d_we1 = 1'b0; d_addr1 = 16'h0031; if_req1 = 1'b1; if_addr1 = 16'h0077;
        @(negedge clk);
        chk("l1_fetch_first", {mem_re1, mem_addr1}, {1'b1, 16'h0077});
        @(negedge clk);
        chk("l1_if_done", if_done1, 1'b1);
        chk("l1_if_rdata", if_rdata1, rd(16'h0077));
        if_req1 = 1'b0;
        @(negedge clk);
        chk("l1_data_next", {mem_re1, mem_addr1}, {1'b1, 16'h0031});
        @(negedge clk);
        chk("l1_d_done", d_done1, 1'b1);
        chk("l1_d_rdata", d_rdata1, rd(16'h0031));
        d_re1 = 1'b0;
        @(negedge clk);
        chk("l1_idle", {mem_re1, mem_we1, d_stall1, if_stall1}, 0);

        fork
            begin : fetch_drv
                int lat, oth, gap;
                for (int i = 0; i < 24; i++) begin
                    fetch_txn(16'($urandom), lat, oth);
                    chk_range("rnd_f_lat", lat, L + 1, 2 * L + 2);
                    chk_range("rnd_f_fair", oth, 0, 1);
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        if_req = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                end
                if_req = 1'b0;
            end
            begin : data_drv
                int lat, oth, gap;
                for (int i = 0; i < 24; i++) begin
                    data_txn($urandom_range(0, 2), 16'($urandom), 16'($urandom), lat, oth);
                    chk_range("rnd_d_lat", lat, L + 1, 2 * L + 2);
                    chk_range("rnd_d_fair", oth, 0, 1);
                    gap = $urandom_range(0, 2);
                    if (gap > 0) begin
                        d_re = 1'b0; d_we = 1'b0;
                        repeat (gap) @(negedge clk);
                    end
                end
                d_re = 1'b0; d_we = 1'b0;
            end
        join

        repeat (3) @(negedge clk);
        chk("fq_drained", fq.size(), 0);
        chk("dq_drained", dq.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
